// File: rtl/nibble_pkg.sv
// Shared constants and helpers for the nibble reduction pipeline.
package nibble_pkg;

  localparam logic [1:0] MODE_MAX = 2'd0;
  localparam logic [1:0] MODE_MIN = 2'd1;
  localparam logic [1:0] MODE_SEL = 2'd2;
  localparam logic [1:0] MODE_XOR = 2'd3;

  // Widest lane the node operator handles; callers zero-extend and truncate.
  localparam int unsigned NIB_MAX_W = 32;
  typedef logic [NIB_MAX_W-1:0] nib_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic nib_t node_op(input logic [1:0] mode, input nib_t lo,
                                   input nib_t hi, input logic steer);
    nib_t res;
    res = lo;
    case (mode)
      MODE_MAX: res = (hi > lo) ? hi : lo;
      MODE_MIN: res = (hi < lo) ? hi : lo;
      MODE_SEL: res = steer ? hi : lo;
      default:  res = lo ^ hi;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nibble_reduce_stage.sv
// One registered level of the reduction tree: halves the lane count and
// consumes the low NODES_IN/2 steering bits.
module nibble_reduce_stage
  import nibble_pkg::*;
#(
  parameter int unsigned NODES_IN = 2,
  parameter int unsigned NIB_W    = 4,
  parameter int unsigned STEER_W  = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         en,
  input  logic [NODES_IN*NIB_W-1:0]    lanes_in,
  input  logic [STEER_W-1:0]           steer_in,
  input  logic [1:0]                   mode_in,
  input  logic                         valid_in,
  output logic [NODES_IN/2*NIB_W-1:0]  lanes_out,
  output logic [STEER_W-1:0]           steer_out,
  output logic [1:0]                   mode_out,
  output logic                         valid_out
);

  localparam int unsigned NODES_OUT = NODES_IN / 2;

  logic [NODES_OUT*NIB_W-1:0] lanes_c;

  for (genvar i = 0; i < NODES_OUT; i++) begin : g_node
    assign lanes_c[i*NIB_W +: NIB_W] = NIB_W'(node_op(
      mode_in,
      NIB_MAX_W'(lanes_in[(2*i)*NIB_W +: NIB_W]),
      NIB_MAX_W'(lanes_in[(2*i+1)*NIB_W +: NIB_W]),
      steer_in[i]));
  end

  // Remaining steering bits shift down so the next level always starts at bit 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lanes_out <= '0;
      steer_out <= '0;
      mode_out  <= MODE_MAX;
      valid_out <= 1'b0;
    end else if (en) begin
      lanes_out <= lanes_c;
      steer_out <= steer_in >> NODES_OUT;
      mode_out  <= mode_in;
      valid_out <= valid_in;
    end
  end

endmodule

// File: rtl/nibble_reduce_pipe.sv
// Pipelined nibble reducer: picks vector A or B, then folds it to one nibble
// through LEVELS registered tree stages under a single global enable.
module nibble_reduce_pipe
  import nibble_pkg::*;
#(
  parameter int unsigned NIB_W   = 4,
  parameter int unsigned NUM_NIB = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [NUM_NIB*NIB_W-1:0]  DATA_A,
  input  logic [NUM_NIB*NIB_W-1:0]  DATA_B,
  input  logic [NUM_NIB-2:0]        SEL_A,
  input  logic [NUM_NIB-2:0]        SEL_B,
  input  logic                      SEL_AB,
  input  logic [1:0]                MODE,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [NIB_W-1:0]          DATA_OUT,
  output logic [CNT_W-1:0]          OUT_COUNT
);

  localparam int unsigned LEVELS = clog2(NUM_NIB);
  localparam int unsigned DW     = NUM_NIB * NIB_W;
  localparam int unsigned SW     = NUM_NIB - 1;
  // All levels' lanes packed back to back: stage 0 at the bottom, root on top.
  localparam int unsigned BUS_W  = (2 * NUM_NIB - 1) * NIB_W;

  logic             en;
  logic [BUS_W-1:0] lane_bus;
  logic [SW-1:0]    steer_s [LEVELS+1];
  logic [1:0]       mode_s  [LEVELS+1];
  logic             valid_s [LEVELS+1];

  logic [DW-1:0]    s0_lanes;
  logic [SW-1:0]    s0_steer;
  logic [1:0]       s0_mode;
  logic             s0_valid;

  assign en       = ~RESET & ~(OUT_VALID & ~OUT_READY);
  assign IN_READY = en;

  // Input register; valid captures IN_VALID only on enabled cycles, i.e. accept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s0_lanes <= '0;
      s0_steer <= '0;
      s0_mode  <= MODE_MAX;
      s0_valid <= 1'b0;
    end else if (en) begin
      s0_lanes <= SEL_AB ? DATA_B : DATA_A;
      s0_steer <= SEL_AB ? SEL_B : SEL_A;
      s0_mode  <= MODE;
      s0_valid <= IN_VALID;
    end
  end

  assign lane_bus[DW-1:0] = s0_lanes;
  assign steer_s[0]       = s0_steer;
  assign mode_s[0]        = s0_mode;
  assign valid_s[0]       = s0_valid;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned N_IN    = NUM_NIB >> (l - 1);
    localparam int unsigned OFF_IN  = (2 * NUM_NIB - 2 * N_IN) * NIB_W;
    localparam int unsigned OFF_OUT = (2 * NUM_NIB - N_IN) * NIB_W;

    nibble_reduce_stage #(
      .NODES_IN (N_IN),
      .NIB_W    (NIB_W),
      .STEER_W  (SW)
    ) u_stage (
      .CLK       (CLK),
      .RESET     (RESET),
      .en        (en),
      .lanes_in  (lane_bus[OFF_IN +: N_IN*NIB_W]),
      .steer_in  (steer_s[l-1]),
      .mode_in   (mode_s[l-1]),
      .valid_in  (valid_s[l-1]),
      .lanes_out (lane_bus[OFF_OUT +: (N_IN/2)*NIB_W]),
      .steer_out (steer_s[l]),
      .mode_out  (mode_s[l]),
      .valid_out (valid_s[l])
    );
  end

  assign OUT_VALID = valid_s[LEVELS];
  assign DATA_OUT  = lane_bus[BUS_W-1 -: NIB_W];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_COUNT <= '0;
    end else if (OUT_VALID & OUT_READY) begin
      OUT_COUNT <= OUT_COUNT + CNT_W'(1);
    end
  end

endmodule
